capacity_tracker: RTL and testbench
===================================

Name: capacity_tracker

Overview:
- Registered occupancy stage directly downstream of the combinational capacity check.
- Consumes the check's 4-bit next-state target (cap_target) and walks the stored occupancy toward it, one unit per STEP_CYCLES clocks, while the door is open.
- Its cap_curr output is the occupancy the capacity check reads back, closing the loop.
- Publishes full/empty/busy status and a done pulse for the controller.

Parameters:
- WIDTH, 4: width of every capacity bus.
- STEP_CYCLES, 4: clocks per single boarding/alighting unit. Legal range is >=1.
- RESET_CAP, 0: occupancy loaded on reset. Must be <= 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  request to start a transfer; sampled only in IDLE.
- door_open  input  1  level; a transfer only runs while it is high.
- cap_max  input  WIDTH  maximum permitted occupancy.
- cap_target  input  WIDTH  desired occupancy from the capacity check.
- cap_curr  output  WIDTH  registered current occupancy.
- state  output  2  encoding: IDLE=0, LOAD=1, UNLOAD=2, DONE=3.
- busy  output  1  high in LOAD or UNLOAD.
- full  output  1  cap_curr >= cap_max; combinational from registers and cap_max.
- empty  output  1  cap_curr == 0.
- done  output  1  one-cycle pulse on completion of a transfer.

Behaviour:
- Reset (asynchronous, rst=1):
  - cap_curr=RESET_CAP, state=IDLE, internal target_q=0, step counter=0, done=0.
  - busy=0; full and empty follow cap_curr and cap_max.
  - Reset mid-transfer abandons the transfer with no done pulse.
- Target latch: in IDLE with en=1 and door_open=1, latch target_q = min(cap_target, cap_max). Unsigned compare, WIDTH bits.
- Transitions from IDLE on that same edge:
  - target_q > cap_curr -> LOAD
  - target_q < cap_curr -> UNLOAD
  - equal -> DONE
  - Inputs are not sampled again until the next IDLE.
- LOAD:
  - Step counter counts 0..STEP_CYCLES-1.
  - When the counter reaches STEP_CYCLES-1, cap_curr increments and the counter clears.
  - The first increment is STEP_CYCLES cycles after entering LOAD.
  - When the incremented value equals target_q, go to DONE on the same edge.
- UNLOAD: mirror of LOAD with decrement.
- DONE: done=1 for exactly this one cycle, then IDLE unconditionally.
- Door abort: door_open=0 during LOAD or UNLOAD -> IDLE on the next edge.
  - cap_curr keeps its last value, the counter clears, and done is not pulsed.
- Arithmetic safety:
  - cap_curr never wraps. Increment is blocked at 2^WIDTH-1 and at target_q; decrement is blocked at 0.
  - Because target_q is clamped, cap_curr never exceeds cap_max via LOAD.
- cap_max lowered below cap_curr while IDLE:
  - No autonomous change; full=1.
  - Correction only happens through a new en request, whose target is clamped to cap_max and therefore triggers UNLOAD.
- cap_max or cap_target changing mid-transfer: ignored, because target_q is latched.
- en held high: a new transfer starts from the IDLE cycle following DONE, giving back-to-back operation with one IDLE cycle between transfers.
- STEP_CYCLES=1: one unit per clock.

Decomposition:
- Shared package capacity_pkg holds:
  - the WIDTH default;
  - the state encoding constants (ST_IDLE, ST_LOAD, ST_UNLOAD, ST_DONE);
  - a clamp function min_cap(a,b) used here and reusable by the check stage.
- One natural sub-module, step_timer:
  - Parameterised modulo-STEP_CYCLES counter with clear input and terminal-count pulse output.
  - Asynchronous active-high reset on clk/rst.
- The FSM and the occupancy register live in capacity_tracker.

Test Plan:
- Reset and load: RESET_CAP=0, cap_max=8, door_open=1, en pulse with cap_target=3.
  - LOAD entered next edge; cap_curr=1,2,3 at 4, 8 and 12 cycles after entering LOAD.
  - state=DONE and done=1 for one cycle with cap_curr=3, then IDLE.
- Clamp: cap_curr=2, cap_max=5, cap_target=9, en=1.
  - target_q=5; cap_curr ends at 5; full=1; exactly 3 increments occur.
- Unload and empty: cap_curr=3, cap_target=0.
  - Enters UNLOAD; cap_curr 2,1,0; empty=1 at completion; done pulses once.
- Door abort: LOAD toward 6 from 1; drop door_open after cap_curr=3.
  - State=IDLE on the next edge; cap_curr holds at 3; done stays 0; step counter restarts on the next en.
- Equal target and async reset: cap_target=cap_curr=4, en=1.
  - Goes straight to DONE: one-cycle done pulse, cap_curr unchanged.
  - Then rst asserted mid-LOAD, between clock edges: cap_curr returns immediately to RESET_CAP, state=IDLE, busy=0.
- Lowered max: cap_curr=7 IDLE, then cap_max set to 4.
  - full=1 with no change to cap_curr.
  - en with cap_target=7 then unloads to 4 (3 decrements).

Source files
------------

// File: rtl/capacity_pkg.sv
// Shared definitions for the capacity check / capacity tracker pair:
// bus width default, tracker state encoding and the occupancy clamp helper.
package capacity_pkg;

    localparam int CAP_WIDTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Unsigned minimum, used to keep a requested occupancy within the permitted maximum.
    function automatic logic [CAP_WIDTH-1:0] min_cap(
        input logic [CAP_WIDTH-1:0] a,
        input logic [CAP_WIDTH-1:0] b
    );
        min_cap = (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/capacity_tracker_step_timer.sv
// Modulo-STEP_CYCLES counter pacing one boarding/alighting unit; tc is high
// during the last cycle of each step period.
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tc
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Step counter: cleared on request, wraps after the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = run && !clr && (cnt_r == CNT_LAST);

endmodule

// File: rtl/capacity_tracker.sv
// Registered occupancy stage: walks cap_curr toward a latched, clamped target
// one unit per STEP_CYCLES clocks while the door is open.
module capacity_tracker
    import capacity_pkg::*;
#(
    parameter int WIDTH       = CAP_WIDTH,
    parameter int STEP_CYCLES = 4,
    parameter int RESET_CAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             door_open,
    input  logic [WIDTH-1:0] cap_max,
    input  logic [WIDTH-1:0] cap_target,
    output logic [WIDTH-1:0] cap_curr,
    output logic [1:0]       state,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic             done
);

    localparam logic [WIDTH-1:0] CAP_TOP  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CAP_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CAP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] cap_curr_r;
    logic [WIDTH-1:0] cap_nxt_s;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] target_nxt_s;
    logic [WIDTH-1:0] clamp_s;
    logic [WIDTH-1:0] cap_inc_s;
    logic [WIDTH-1:0] cap_dec_s;
    logic             busy_r;
    logic             done_r;
    logic             moving_s;
    logic             tick_s;

    assign clamp_s   = min_cap(cap_target, cap_max);
    assign cap_inc_s = cap_curr_r + CAP_ONE;
    assign cap_dec_s = cap_curr_r - CAP_ONE;
    assign moving_s  = (state_r == ST_LOAD) || (state_r == ST_UNLOAD);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk (clk),
        .rst (rst),
        .clr (!moving_s || !door_open),
        .run (door_open),
        .tc  (tick_s)
    );

    // Next-state, next-occupancy and target latch decisions.
    always_comb begin
        state_nxt_s  = state_r;
        cap_nxt_s    = cap_curr_r;
        target_nxt_s = target_r;
        case (state_r)
            ST_IDLE: begin
                if (en && door_open) begin
                    target_nxt_s = clamp_s;
                    if (clamp_s > cap_curr_r) begin
                        state_nxt_s = ST_LOAD;
                    end else if (clamp_s < cap_curr_r) begin
                        state_nxt_s = ST_UNLOAD;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!door_open) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s && (cap_curr_r != CAP_TOP) && (cap_curr_r != target_r)) begin
                    cap_nxt_s = cap_inc_s;
                    if (cap_inc_s == target_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_UNLOAD: begin
                if (!door_open) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s && (cap_curr_r != CAP_ZERO) && (cap_curr_r != target_r)) begin
                    cap_nxt_s = cap_dec_s;
                    if (cap_dec_s == target_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_UNLOAD;
                    end
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, occupancy and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cap_curr_r <= WIDTH'(RESET_CAP);
            target_r   <= CAP_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cap_curr_r <= cap_nxt_s;
            target_r   <= target_nxt_s;
            busy_r     <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_UNLOAD);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign cap_curr = cap_curr_r;
    assign state    = state_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign full     = (cap_curr_r >= cap_max);
    assign empty    = (cap_curr_r == CAP_ZERO);

endmodule

// File: tb/tb_capacity_tracker.sv
// Directed self-checking bench for capacity_tracker (WIDTH=4, STEP_CYCLES=4, RESET_CAP=0).
module tb_capacity_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] cap_max = 4'd8;
    logic [3:0] cap_target = 4'd0;
    logic [3:0] cap_curr;
    logic [1:0] state;
    logic       busy;
    logic       full;
    logic       empty;
    logic       done;

    int checks = 0;
    int errors = 0;

    capacity_tracker #(
        .WIDTH       (4),
        .STEP_CYCLES (4),
        .RESET_CAP   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .door_open  (door_open),
        .cap_max    (cap_max),
        .cap_target (cap_target),
        .cap_curr   (cap_curr),
        .state      (state),
        .busy       (busy),
        .full       (full),
        .empty      (empty),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Move occupancy to a known value; only the completion timeout is judged here.
    task automatic run_transfer(input logic [3:0] tgt);
        int n;
        cap_target = tgt;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (state != 2'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL transfer_timeout state=%0d required=0", state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        door_open = 1'b1;
        cap_max = 4'd8;
        #12;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cap_curr !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0
            || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset cap=%0d state=%0d busy=%b done=%b empty=%b full=%b required 0 0 0 0 1 0",
                     cap_curr, state, busy, done, empty, full);
        end
    endtask

    task automatic test_load();
        cap_target = 4'd3;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (state !== 2'd1 || busy !== 1'b1 || cap_curr !== 4'd0) begin
            errors++;
            $display("FAIL load_enter state=%0d busy=%b cap=%0d required 1 1 0", state, busy, cap_curr);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3 || k == 4 || k == 8) begin
                checks++;
                if (cap_curr !== 4'(k / 4)) begin
                    errors++;
                    $display("FAIL load_step k=%0d cap=%0d required %0d", k, cap_curr, k / 4);
                end
            end
        end
        checks++;
        if (cap_curr !== 4'd3 || state !== 2'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL load_done cap=%0d state=%0d done=%b required 3 3 1", cap_curr, state, done);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_idle state=%0d done=%b required 0 0", state, done);
        end
    endtask

    task automatic test_unload_empty();
        int dones;
        cap_target = 4'd0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL unload_enter state=%0d required 2", state);
        end
        dones = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (k == 4 || k == 8 || k == 12) begin
                checks++;
                if (cap_curr !== 4'(3 - k / 4)) begin
                    errors++;
                    $display("FAIL unload_step k=%0d cap=%0d required %0d", k, cap_curr, 3 - k / 4);
                end
            end
            if (k == 12) begin
                checks++;
                if (empty !== 1'b1 || state !== 2'd3) begin
                    errors++;
                    $display("FAIL unload_empty empty=%b state=%0d required 1 3", empty, state);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL unload_done_count got=%0d required 1", dones);
        end
    endtask

    task automatic test_clamp();
        int incs;
        logic [3:0] prev;
        run_transfer(4'd2);
        cap_max = 4'd5;
        cap_target = 4'd9;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        incs = 0;
        prev = 4'd2;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cap_curr !== prev) incs++;
            prev = cap_curr;
        end
        checks++;
        if (cap_curr !== 4'd5 || full !== 1'b1 || incs != 3 || state !== 2'd0) begin
            errors++;
            $display("FAIL clamp cap=%0d full=%b incs=%0d state=%0d required 5 1 3 0",
                     cap_curr, full, incs, state);
        end
    endtask

    task automatic test_door_abort();
        cap_max = 4'd8;
        run_transfer(4'd1);
        cap_target = 4'd6;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (cap_curr !== 4'd3 || state !== 2'd1) begin
            errors++;
            $display("FAIL abort_pre cap=%0d state=%0d required 3 1", cap_curr, state);
        end
        door_open = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || cap_curr !== 4'd3 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort state=%0d cap=%0d done=%b busy=%b required 0 3 0 0",
                     state, cap_curr, done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || cap_curr !== 4'd3) begin
            errors++;
            $display("FAIL abort_hold done=%b cap=%0d required 0 3", done, cap_curr);
        end
        door_open = 1'b1;
        cap_target = 4'd4;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cap_curr !== 4'd3) begin
            errors++;
            $display("FAIL abort_restart_early cap=%0d required 3", cap_curr);
        end
        @(negedge clk);
        checks++;
        if (cap_curr !== 4'd4 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart cap=%0d done=%b required 4 1", cap_curr, done);
        end
        @(negedge clk);
    endtask

    task automatic test_equal_and_async_reset();
        cap_target = 4'd4;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (state !== 2'd3 || done !== 1'b1 || cap_curr !== 4'd4) begin
            errors++;
            $display("FAIL equal state=%0d done=%b cap=%0d required 3 1 4", state, done, cap_curr);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL equal_idle state=%0d done=%b required 0 0", state, done);
        end
        cap_target = 4'd8;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (cap_curr !== 4'd5 || state !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset cap=%0d state=%0d required 5 1", cap_curr, state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cap_curr !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset cap=%0d state=%0d busy=%b done=%b required 0 0 0 0",
                     cap_curr, state, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lowered_max();
        int decs;
        logic [3:0] prev;
        cap_max = 4'd8;
        run_transfer(4'd7);
        cap_max = 4'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (full !== 1'b1 || cap_curr !== 4'd7 || state !== 2'd0) begin
            errors++;
            $display("FAIL lowered_idle full=%b cap=%0d state=%0d required 1 7 0", full, cap_curr, state);
        end
        cap_target = 4'd7;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL lowered_unload state=%0d required 2", state);
        end
        decs = 0;
        prev = 4'd7;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cap_curr !== prev) decs++;
            prev = cap_curr;
        end
        checks++;
        if (cap_curr !== 4'd4 || decs != 3 || full !== 1'b1) begin
            errors++;
            $display("FAIL lowered_final cap=%0d decs=%0d full=%b required 4 3 1", cap_curr, decs, full);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_unload_empty();
        test_clamp();
        test_door_abort();
        test_equal_and_async_reset();
        test_lowered_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
